// File: rtl/dbus_ctrl.sv
// dbus_ctrl: load/store bus controller routing core accesses to data memory or the Wishbone RSA slave.
// Ports: clk, rst (async, active-low); core_* request/response handshake with the core;
// mem_* data memory port (one-cycle access); rsa_* Wishbone port (held until ack or timeout);
// busy flags any in-flight access.
module dbus_ctrl #(
    parameter logic [31:0] RSA_BASE = 32'h4000_0000,
    parameter logic [31:0] RSA_MASK = 32'hFFFF_F000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_we,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    output logic        core_err,
    output logic        busy,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        rsa_en,
    output logic [31:0] rsa_adr,
    output logic [31:0] rsa_dat_o,
    output logic        rsa_we,
    input  logic [31:0] rsa_dat_i,
    input  logic        rsa_ack
);
    typedef enum logic [1:0] {IDLE, MEM, RSA, RESP} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_we;
    logic        r_err;
    logic [15:0] r_cnt;
    logic        w_hit, w_expire;
    assign w_hit    = (core_addr & RSA_MASK) == RSA_BASE;
    // r_cnt holds the number of RSA cycles already elapsed, so this is the TIMEOUT-th cycle
    assign w_expire = r_cnt == LAST;
    always_comb begin
        w_next     = r_state;
        mem_en     = r_state == MEM;
        rsa_en     = r_state == RSA;
        core_ready = r_state == RESP;
        busy       = r_state != IDLE;
        mem_we     = mem_en ? r_we : 4'd0;
        rsa_we     = rsa_en & (|r_we);
        core_err   = core_ready & r_err;
        core_rdata = r_rdata;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        rsa_adr    = r_addr;
        rsa_dat_o  = r_wdata;
        case (r_state)
            IDLE:    w_next = core_req ? (w_hit ? RSA : MEM) : IDLE;
            MEM:     w_next = RESP;
            RSA:     w_next = (rsa_ack || w_expire) ? RESP : RSA;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (core_req) begin
                    r_addr  <= core_addr;
                    r_wdata <= core_wdata;
                    r_we    <= core_we;
                end
                MEM: begin
                    r_rdata <= mem_rdata;
                    r_err   <= 1'b0;
                end
                RSA: if (rsa_ack) begin
                    // an ack in the expiry cycle still counts as success
                    r_rdata <= rsa_dat_i;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                end else if (w_expire) begin
                    r_rdata <= ERR_DATA;
                    r_err   <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
Data-bus controller between the RV32I datapath's load/store port and its two slaves: the word-addressed data memory and the Wishbone RSA peripheral. It decodes each core access by address, sequences exactly one slave transaction, and returns data with a one-cycle completion pulse. The core stalls until that pulse arrives. It replaces direct wiring of mem_en/rsa_en from the datapath and adds a bus-timeout error path.

Parameters:
RSA_BASE, 32'h4000_0000, base address of RSA register window
RSA_MASK, 32'hFFFF_F000, address bits compared for an RSA hit
TIMEOUT, 255, max cycles rsa_en is held waiting for ack (1..65535)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  asynchronous reset, active-low
core_req  input  1  access request; held by core until core_ready
core_addr  input  32  byte address
core_wdata  input  32  store data
core_we  input  4  byte write enables; 0 = load
core_rdata  output  32  load data, valid while core_ready=1
core_ready  output  1  one-cycle completion pulse
core_err  output  1  asserted with core_ready on RSA timeout
busy  output  1  high in any state other than IDLE
mem_en  output  1  data memory select
mem_addr  output  32  latched address to memory
mem_wdata  output  32  latched store data
mem_we  output  4  latched byte enables, gated by mem_en
mem_rdata  input  32  memory read data
rsa_en  output  1  Wishbone cyc/stb to RSA
rsa_adr  output  32  latched address to RSA
rsa_dat_o  output  32  latched store data to RSA
rsa_we  output  1  OR-reduction of latched core_we
rsa_dat_i  input  32  RSA read data
rsa_ack  input  1  RSA acknowledge

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; latches and timeout counter 0. Reset mid-transaction aborts it; no ready pulse follows.
- States: IDLE, MEM, RSA, RESP.
- IDLE: if core_req=1, latch addr/wdata/we. Hit = ((core_addr & RSA_MASK) == RSA_BASE). Hit -> RSA, else -> MEM. Requests are sampled only in IDLE.
- MEM (exactly 1 cycle): mem_en=1, mem_we=latched we. Capture mem_rdata at the closing edge. -> RESP.
- RSA: rsa_en=1 and rsa_we held stable; counter increments each cycle.
  - rsa_ack=1: capture rsa_dat_i, clear counter, -> RESP, err=0.
  - Counter reaches TIMEOUT with no ack: rdata=ERR_DATA, err=1, -> RESP.
  - Ack in the expiry cycle: ack wins, err=0.
- RESP (1 cycle): core_ready=1, core_rdata=captured data, core_err per above. -> IDLE.
- Latency from the req-sampling edge: memory access core_ready in cycle +2. RSA access core_ready 1 cycle after the ack cycle.
- Back-to-back: a request held high in RESP is not accepted until the following IDLE cycle. Minimum spacing is 3 cycles for memory accesses.
- Writes: core_rdata=captured slave data (don't-care for the core), still driven deterministically.
- core_req dropping mid-transaction does not abort; core_ready still pulses.
- rsa_ack outside the RSA state is ignored.
- mem_en and rsa_en are never high in the same cycle.
- Outside MEM/RSA: mem_we=0, rsa_en=0. Address/data outputs hold the last latched values.
- No alignment checks; the address passes through unchanged.

Test Plan:
- Reset: rst=0 mid-RSA access -> all outputs 0 immediately. After release, busy=0 and no core_ready pulse.
- Memory store then load: req addr=0x0000_0010, we=4'hF, wdata=0x1234_5678 -> mem_en for 1 cycle, ready at +2. Load same addr, we=0 -> core_rdata=0x1234_5678 at +2, err=0.
- RSA read: addr=0x4000_0008, we=0, slave acks after 5 cycles with 0xCAFE_0001 -> rsa_en high 5 cycles, mem_en never high. Ready 1 cycle after ack, rdata=0xCAFE_0001, err=0.
- RSA timeout: TIMEOUT=8, no ack -> rsa_en drops after 8 cycles, ready with err=1, rdata=0xDEAD_BEEF. Repeat with ack in cycle 8 -> err=0, data from the slave.
- Decode boundary: addr=0x3FFF_FFFC routes to memory; 0x4000_0FFC routes to RSA; 0x4000_1000 routes to memory.
- Back-to-back and stray ack: core_req held high for 3 memory loads -> ready pulses 3 cycles apart. rsa_ack pulsed in IDLE -> no state change.
